// File: rtl/kronos_types.sv
// kronos_types: shared definitions for the writeback arbiter slice.
//   WB_ALU/WB_LSU/WB_CSR - requester indices on the write-port arbiter
//   WB_NREQ              - number of writeback requesters
//   WB_PEND_W            - width of each per-register pending-write counter
//   wb_req_t             - one writeback request: destination register and data
package kronos_types;

    localparam int WB_ALU    = 0;
    localparam int WB_LSU    = 1;
    localparam int WB_CSR    = 2;
    localparam int WB_NREQ   = 3;
    localparam int WB_PEND_W = 2;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/kronos_rr_arb.sv
// kronos_rr_arb: generic N-way arbiter with a combinational one-hot grant.
//   FAIR=1: round-robin. The pointer names the highest-priority index, and
//           after a grant to i it moves to (i+1) mod N.
//   FAIR=0: fixed priority, where index 0 is highest. The pointer is ignored.
// Ports:
//   clk, rstz - clock, asynchronous active-low reset (pointer -> 0)
//   req       - request vector
//   gnt       - one-hot grant, or zero when there is no request
module kronos_rr_arb #(
    parameter int N    = 3,
    parameter bit FAIR = 1'b1
) (
    input  logic         clk,
    input  logic         rstz,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;
    int            idx;

    // Walk the requesters starting at the priority index. The first valid
    // requester found wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = FAIR ? ((int'(ptr) + k) % N) : k;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) ptr_nxt = PW'((i + 1) % N);
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) ptr <= '0;
        else       ptr <= ptr_nxt;
    end

endmodule

// File: rtl/kronos_wb_arbiter.sv
// kronos_wb_arbiter: register-file write-port arbiter and writeback scoreboard.
// Three requesters (ALU, LSU, CSR) share one registered write port. A
// saturating pending-write counter per register (x1..x31) drives busy for
// the hazard logic.
// Ports:
//   clk, rstz              - clock, asynchronous active-low reset
//   req_vld/req_rdy        - per-requester valid and grant (grant is one-hot or zero)
//   req_sel/req_data       - per-requester destination register and write data
//   rsv_en/rsv_sel/rsv_rdy - reserve a pending write at issue
//   regwr_en/sel/data      - registered write port to decode
//   busy                   - bit r is set while register r has uncommitted writes
module kronos_wb_arbiter
    import kronos_types::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic                      clk,
    input  logic                      rstz,
    input  logic [WB_NREQ-1:0]        req_vld,
    output logic [WB_NREQ-1:0]        req_rdy,
    input  logic [WB_NREQ-1:0][4:0]   req_sel,
    input  logic [WB_NREQ-1:0][31:0]  req_data,
    input  logic                      rsv_en,
    input  logic [4:0]                rsv_sel,
    output logic                      rsv_rdy,
    output logic                      regwr_en,
    output logic [4:0]                regwr_sel,
    output logic [31:0]               regwr_data,
    output logic [31:0]               busy
);

    localparam logic [WB_PEND_W-1:0] PEND_MAX = '1;

    wb_req_t                reqs [WB_NREQ];
    wb_req_t                win;
    logic                   acc;
    logic                   rsv_fire;
    logic [WB_PEND_W-1:0]   cnt [1:31];
    logic [WB_PEND_W-1:0]   cnt_rsv;

    kronos_rr_arb #(
        .N    (WB_NREQ),
        .FAIR (FAIR)
    ) u_arb (
        .clk  (clk),
        .rstz (rstz),
        .req  (req_vld),
        .gnt  (req_rdy)
    );

    always_comb begin
        for (int i = 0; i < WB_NREQ; i++) begin
            reqs[i].sel  = req_sel[i];
            reqs[i].data = req_data[i];
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < WB_NREQ; i++) begin
            if (req_rdy[i]) win = reqs[i];
        end
    end

    assign acc = |req_rdy;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            regwr_en   <= 1'b0;
            regwr_sel  <= '0;
            regwr_data <= '0;
        end else begin
            regwr_en <= acc && (win.sel != 5'd0);
            if (acc) begin
                regwr_sel  <= win.sel;
                regwr_data <= win.data;
            end
        end
    end

    // The reservation check uses only the registered count. A decrement on
    // the same edge does not let a reservation into a full counter.
    always_comb begin
        cnt_rsv = '0;
        for (int r = 1; r < 32; r++) begin
            if (rsv_sel == 5'(r)) cnt_rsv = cnt[r];
        end
    end

    assign rsv_rdy  = (rsv_sel == 5'd0) || (cnt_rsv != PEND_MAX);
    assign rsv_fire = rsv_en && rsv_rdy && (rsv_sel != 5'd0);

    // A commit decrements on the same edge that raises regwr_en. So busy
    // drops in the cycle that the forwarded data appears.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            for (int r = 1; r < 32; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (rsv_fire && (rsv_sel == 5'(r)) && !(acc && (win.sel == 5'(r))))
                    cnt[r] <= cnt[r] + 1'b1;
                else if (acc && (win.sel == 5'(r)) && !(rsv_fire && (rsv_sel == 5'(r)))
                         && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) busy[r] = (cnt[r] != '0);
    end

endmodule

// File: tb/tb_kronos_wb_arbiter.sv
module tb_kronos_wb_arbiter;

    logic             clk = 1'b0;
    logic             rstz;
    logic [2:0]       req_vld;
    logic [2:0][4:0]  req_sel;
    logic [2:0][31:0] req_data;
    logic             rsv_en;
    logic [4:0]       rsv_sel;

    logic [2:0]  req_rdy,    fp_req_rdy;
    logic        rsv_rdy,    fp_rsv_rdy;
    logic        regwr_en,   fp_regwr_en;
    logic [4:0]  regwr_sel,  fp_regwr_sel;
    logic [31:0] regwr_data, fp_regwr_data;
    logic [31:0] busy,       fp_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    kronos_wb_arbiter #(.FAIR(1'b1)) dut (
        .clk(clk), .rstz(rstz), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_sel(req_sel), .req_data(req_data), .rsv_en(rsv_en),
        .rsv_sel(rsv_sel), .rsv_rdy(rsv_rdy), .regwr_en(regwr_en),
        .regwr_sel(regwr_sel), .regwr_data(regwr_data), .busy(busy)
    );

    kronos_wb_arbiter #(.FAIR(1'b0)) dut_fp (
        .clk(clk), .rstz(rstz), .req_vld(req_vld), .req_rdy(fp_req_rdy),
        .req_sel(req_sel), .req_data(req_data), .rsv_en(rsv_en),
        .rsv_sel(rsv_sel), .rsv_rdy(fp_rsv_rdy), .regwr_en(fp_regwr_en),
        .regwr_sel(fp_regwr_sel), .regwr_data(fp_regwr_data), .busy(fp_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_vld  = '0;
        req_sel  = '0;
        req_data = '0;
        rsv_en   = 1'b0;
        rsv_sel  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstz = 1'b0;
        #3;
        rstz = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstz = 1'b0;
        #2;
        tests++; if (regwr_en !== 1'b0) begin fails++; $display("FAIL reset_regwr_en got=%b exp=0", regwr_en); end
        tests++; if (regwr_sel !== 5'd0) begin fails++; $display("FAIL reset_regwr_sel got=%0d exp=0", regwr_sel); end
        tests++; if (regwr_data !== 32'h0) begin fails++; $display("FAIL reset_regwr_data got=%h exp=0", regwr_data); end
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL reset_busy got=%h exp=0", busy); end
        tests++; if (req_rdy !== 3'b000) begin fails++; $display("FAIL reset_req_rdy got=%b exp=000", req_rdy); end
        tests++; if (rsv_rdy !== 1'b1) begin fails++; $display("FAIL reset_rsv_rdy got=%b exp=1", rsv_rdy); end
        tick();
        rstz = 1'b1;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        req_vld     = 3'b001;
        req_sel[0]  = 5'd5;
        req_data[0] = 32'hDEADBEEF;
        #1;
        tests++; if (req_rdy !== 3'b001) begin fails++; $display("FAIL single_req_rdy got=%b exp=001", req_rdy); end
        tick();
        req_vld = 3'b000;
        tests++; if (regwr_en !== 1'b1) begin fails++; $display("FAIL single_en got=%b exp=1", regwr_en); end
        tests++; if (regwr_sel !== 5'd5) begin fails++; $display("FAIL single_sel got=%0d exp=5", regwr_sel); end
        tests++; if (regwr_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data got=%h exp=deadbeef", regwr_data); end
        tick();
        tests++; if (regwr_en !== 1'b0) begin fails++; $display("FAIL single_en_drop got=%b exp=0", regwr_en); end
        tests++; if (regwr_sel !== 5'd5 || regwr_data !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_hold got=%0d/%h exp=5/deadbeef", regwr_sel, regwr_data);
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp_rdy;
        logic [4:0] exp_sel;
        do_reset();
        req_vld  = 3'b111;
        req_sel  = {5'd3, 5'd2, 5'd1};
        req_data = {32'hC, 32'hB, 32'hA};
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_rdy = 3'b001 << (k % 3);
            exp_sel = 5'((k % 3) + 1);
            tests++; if (req_rdy !== exp_rdy) begin fails++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, req_rdy, exp_rdy); end
            tests++; if (fp_req_rdy !== 3'b001) begin fails++; $display("FAIL fixed_grant_%0d got=%b exp=001", k, fp_req_rdy); end
            tick();
            tests++; if (regwr_en !== 1'b1 || regwr_sel !== exp_sel) begin
                fails++; $display("FAIL rr_write_%0d got=%b/%0d exp=1/%0d", k, regwr_en, regwr_sel, exp_sel);
            end
            tests++; if (fp_regwr_sel !== 5'd1) begin fails++; $display("FAIL fixed_write_%0d got=%0d exp=1", k, fp_regwr_sel); end
        end
        req_vld = 3'b000;
    endtask

    task automatic test_x0();
        do_reset();
        req_vld     = 3'b010;
        req_sel[1]  = 5'd0;
        req_data[1] = 32'h1234;
        #1;
        tests++; if (req_rdy !== 3'b010) begin fails++; $display("FAIL x0_req_rdy got=%b exp=010", req_rdy); end
        tick();
        req_vld = 3'b000;
        tests++; if (regwr_en !== 1'b0) begin fails++; $display("FAIL x0_en got=%b exp=0", regwr_en); end
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL x0_busy got=%h exp=0", busy); end
    endtask

    task automatic commit_alu(input logic [4:0] sel, input logic [31:0] data);
        req_vld     = 3'b001;
        req_sel[0]  = sel;
        req_data[0] = data;
        tick();
        req_vld = 3'b000;
    endtask

    task automatic test_scoreboard();
        do_reset();
        rsv_en  = 1'b1;
        rsv_sel = 5'd7;
        tick();
        tick();
        rsv_en = 1'b0;
        tests++; if (busy !== 32'h80) begin fails++; $display("FAIL sb_reserved got=%h exp=00000080", busy); end
        commit_alu(5'd7, 32'h11);
        tests++; if (regwr_en !== 1'b1 || busy !== 32'h80) begin
            fails++; $display("FAIL sb_commit1 got=%b/%h exp=1/00000080", regwr_en, busy);
        end
        commit_alu(5'd7, 32'h22);
        tests++; if (regwr_en !== 1'b1 || regwr_sel !== 5'd7 || busy !== 32'h0) begin
            fails++; $display("FAIL sb_commit2 got=%b/%0d/%h exp=1/7/0", regwr_en, regwr_sel, busy);
        end
        rsv_en = 1'b1;
        rsv_sel = 5'd7;
        tick();
        req_vld     = 3'b001;
        req_sel[0]  = 5'd7;
        req_data[0] = 32'h33;
        tick();
        rsv_en  = 1'b0;
        req_vld = 3'b000;
        tests++; if (busy !== 32'h80) begin fails++; $display("FAIL sb_same_edge got=%h exp=00000080", busy); end
        commit_alu(5'd7, 32'h44);
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL sb_same_edge_drain got=%h exp=0", busy); end
        commit_alu(5'd7, 32'h55);
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL sb_unreserved got=%h exp=0", busy); end
    endtask

    task automatic test_saturation();
        do_reset();
        rsv_en  = 1'b1;
        rsv_sel = 5'd3;
        tick();
        tick();
        tick();
        tests++; if (rsv_rdy !== 1'b0) begin fails++; $display("FAIL sat_rdy3 got=%b exp=0", rsv_rdy); end
        tick();
        rsv_en  = 1'b0;
        rsv_sel = 5'd4;
        #1;
        tests++; if (rsv_rdy !== 1'b1) begin fails++; $display("FAIL sat_rdy4 got=%b exp=1", rsv_rdy); end
        rsv_sel = 5'd0;
        #1;
        tests++; if (rsv_rdy !== 1'b1) begin fails++; $display("FAIL sat_rdy0 got=%b exp=1", rsv_rdy); end
        rsv_sel     = 5'd3;
        req_vld     = 3'b001;
        req_sel[0]  = 5'd3;
        req_data[0] = 32'h77;
        #1;
        tests++; if (rsv_rdy !== 1'b0) begin fails++; $display("FAIL sat_same_cycle got=%b exp=0", rsv_rdy); end
        tick();
        req_vld = 3'b000;
        tests++; if (rsv_rdy !== 1'b1) begin fails++; $display("FAIL sat_after_commit got=%b exp=1", rsv_rdy); end
        commit_alu(5'd3, 32'h78);
        commit_alu(5'd3, 32'h79);
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL sat_drain got=%h exp=0", busy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        rsv_en  = 1'b1;
        rsv_sel = 5'd3;
        tick();
        rsv_sel = 5'd7;
        tick();
        rsv_en = 1'b0;
        commit_alu(5'd1, 32'hABCD);
        tests++; if (regwr_en !== 1'b1 || busy !== 32'h88) begin
            fails++; $display("FAIL areset_pre got=%b/%h exp=1/00000088", regwr_en, busy);
        end
        req_vld  = 3'b111;
        req_sel  = {5'd3, 5'd2, 5'd1};
        #1;
        tests++; if (req_rdy !== 3'b010) begin fails++; $display("FAIL areset_ptr_pre got=%b exp=010", req_rdy); end
        rstz = 1'b0;
        #1;
        tests++; if (regwr_en !== 1'b0 || busy !== 32'h0 || regwr_sel !== 5'd0) begin
            fails++; $display("FAIL areset_outputs got=%b/%h/%0d exp=0/0/0", regwr_en, busy, regwr_sel);
        end
        tests++; if (req_rdy !== 3'b001) begin fails++; $display("FAIL areset_ptr got=%b exp=001", req_rdy); end
        rstz = 1'b1;
        clear_inputs();
        tick();
    endtask

    initial begin
        rstz = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_scoreboard();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
